instr_decode_stage: RTL and testbench
=====================================

// Module: instr_decode_stage
// PURPOSE
//  Instruction Decode (ID) stage of the 5-stage MIPS pipeline. Consumes the IF/ID latch outputs
//  (instruction and NPC) and decodes control. Holds the 32x32 register file and takes writes from MEM/WB.
//  Registers decoded control, operands, sign-extended immediate and rt/rd fields into the ID/EX latch.
// PARAMETERS
//  DATA_W   32  datapath / register width
//  REG_CNT  32  register file depth (5-bit addresses)
// PORTS
//  clk              in   1   single clock; all state updates on posedge
//  rst              in   1   synchronous, active-high reset
//  IF_ID_INSTR      in   32  instruction from IF/ID latch
//  IF_ID_NPC        in   32  PC+4 from IF/ID latch
//  id_flush         in   1   branch taken (EX_MEM_PCSrc); bubble ID/EX control
//  MEM_WB_RegWrite  in   1   write-back enable
//  MEM_WB_WriteReg  in   5   write-back destination register
//  MEM_WB_WriteData in   32  write-back data
//  ID_EX_WB         out  2   {RegWrite, MemtoReg}
//  ID_EX_M          out  3   {Branch, MemRead, MemWrite}
//  ID_EX_EX         out  4   {RegDst, ALUOp[1:0], ALUSrc}
//  ID_EX_NPC        out  32  registered IF_ID_NPC
//  ID_EX_RD1        out  32  registered rs read data
//  ID_EX_RD2        out  32  registered rt read data
//  ID_EX_SEXT       out  32  registered sign-extended instr[15:0]
//  ID_EX_RT         out  5   registered instr[20:16]
//  ID_EX_RD         out  5   registered instr[15:11]
// BEHAVIOUR
//  - Reset (rst=1 at posedge): all ID_EX_* outputs <= 0; all 32 registers <= 0. Reset overrides everything.
//  - Latency: 1 cycle. Inputs present at posedge N appear on ID_EX_* after posedge N. No stall/handshake;
//    the latch loads every cycle.
//  - Decode on opcode instr[31:26] (EX / M / WB):
//      0x00 R-type : 1100 / 000 / 10
//      0x23 lw     : 0001 / 010 / 11
//      0x2B sw     : 0001 / 001 / 00
//      0x04 beq    : 0010 / 100 / 00
//      any other   : 0000 / 000 / 00 (bubble); data fields still latched
//  - All-zero instruction (nop) decodes as R-type writing $0. It is harmless because $0 is never written.
//  - id_flush=1: ID_EX_WB/M/EX <= 0. Data fields are still latched.
//  - Register file: reads are combinational on rs=instr[25:21] and rt=instr[20:16].
//    Write at posedge when MEM_WB_RegWrite=1 and MEM_WB_WriteReg!=0.
//  - $0 always reads 0. Writes to $0 are dropped.
//  - Same-cycle write/read of the same non-zero register: read returns MEM_WB_WriteData (internal bypass).
//    The bypass is qualified by RegWrite=1.
//  - Sign extend: SEXT = {{16{instr[15]}}, instr[15:0]}. No zero-extend path.
//  - Write-back during rst=1 is discarded. The register file is cleared that cycle.
// STRUCTURE
//  - Shared package: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ) and control field encodings
//    (CTRL_EX_*, CTRL_M_*, CTRL_WB_*). The EX/MEM stage also uses the package.
//  - One sub-module: reg_file (2 read ports, 1 write port, $0 hardwired, write-through bypass).
//  - Control decode and the ID/EX latch live in this module.
// TESTING
//  1. Assert rst for 2 cycles, then release -> all ID_EX_* = 0; reading any register returns 0.
//  2. Preload $1=5, $2=7. Drive instr=0x00221820 (add $3,$1,$2), NPC=0x4
//     -> next cycle: EX=1100, M=000, WB=10, RD1=5, RD2=7, RT=2, RD=3, NPC=0x4.
//  3. instr=0x8C22FFFC (lw $2,-4($1)) -> SEXT=0xFFFFFFFC, EX=0001, M=010, WB=11, RT=2.
//  4. Same cycle: RegWrite=1, WriteReg=1, WriteData=0xDEADBEEF, and instr reads rs=$1
//     -> RD1=0xDEADBEEF. Then write 0x1234 to $0 -> $0 reads 0.
//  5. Opcode 0x3F -> WB/M/EX=0. Separately, beq with id_flush=1 -> control=0 and NPC still latched.
//  6. Assert rst mid-stream after lw is latched -> next cycle all outputs 0 and $1 reads 0.

Source files
------------

// File: rtl/instr_decode_stage_pkg.sv
// rtl/instr_decode_stage_pkg.sv - opcode and control-field encodings shared by ID and EX/MEM
package instr_decode_stage_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_CNT = 32;
  localparam int ADDR_W  = $clog2(REG_CNT);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  // EX = {RegDst, ALUOp[1:0], ALUSrc}
  localparam logic [3:0] CTRL_EX_RTYPE = 4'b1100;
  localparam logic [3:0] CTRL_EX_LW    = 4'b0001;
  localparam logic [3:0] CTRL_EX_SW    = 4'b0001;
  localparam logic [3:0] CTRL_EX_BEQ   = 4'b0010;
  localparam logic [3:0] CTRL_EX_NONE  = 4'b0000;

  // M = {Branch, MemRead, MemWrite}
  localparam logic [2:0] CTRL_M_RTYPE = 3'b000;
  localparam logic [2:0] CTRL_M_LW    = 3'b010;
  localparam logic [2:0] CTRL_M_SW    = 3'b001;
  localparam logic [2:0] CTRL_M_BEQ   = 3'b100;
  localparam logic [2:0] CTRL_M_NONE  = 3'b000;

  // WB = {RegWrite, MemtoReg}
  localparam logic [1:0] CTRL_WB_RTYPE = 2'b10;
  localparam logic [1:0] CTRL_WB_LW    = 2'b11;
  localparam logic [1:0] CTRL_WB_SW    = 2'b00;
  localparam logic [1:0] CTRL_WB_BEQ   = 2'b00;
  localparam logic [1:0] CTRL_WB_NONE  = 2'b00;

  typedef struct packed {
    logic [1:0] wb;
    logic [2:0] m;
    logic [3:0] ex;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
    ctrl_t c;
    case (opcode)
      OP_RTYPE: c = '{wb: CTRL_WB_RTYPE, m: CTRL_M_RTYPE, ex: CTRL_EX_RTYPE};
      OP_LW:    c = '{wb: CTRL_WB_LW,    m: CTRL_M_LW,    ex: CTRL_EX_LW};
      OP_SW:    c = '{wb: CTRL_WB_SW,    m: CTRL_M_SW,    ex: CTRL_EX_SW};
      OP_BEQ:   c = '{wb: CTRL_WB_BEQ,   m: CTRL_M_BEQ,   ex: CTRL_EX_BEQ};
      default:  c = '{wb: CTRL_WB_NONE,  m: CTRL_M_NONE,  ex: CTRL_EX_NONE};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/instr_decode_stage_reg_file.sv
// rtl/instr_decode_stage_reg_file.sv - 2R/1W register file, $0 hardwired, write-through bypass
module instr_decode_stage_reg_file
  import instr_decode_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_raddr1,
  input  logic [ADDR_W-1:0] i_raddr2,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata
);

  logic [DATA_W-1:0] r_regs [REG_CNT];
  logic              w_wr_en;

  assign w_wr_en = i_we && (i_waddr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // A write landing this cycle is forwarded so ID sees the value WB is committing
  always_comb begin
    o_rdata1 = r_regs[i_raddr1];
    o_rdata2 = r_regs[i_raddr2];
    if (w_wr_en && (i_waddr == i_raddr1)) o_rdata1 = i_wdata;
    if (w_wr_en && (i_waddr == i_raddr2)) o_rdata2 = i_wdata;
    if (i_raddr1 == '0) o_rdata1 = '0;
    if (i_raddr2 == '0) o_rdata2 = '0;
  end

endmodule

// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - MIPS ID stage: control decode, register read, ID/EX latch
module instr_decode_stage
  import instr_decode_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] IF_ID_INSTR,
  input  logic [DATA_W-1:0] IF_ID_NPC,
  input  logic              id_flush,
  input  logic              MEM_WB_RegWrite,
  input  logic [ADDR_W-1:0] MEM_WB_WriteReg,
  input  logic [DATA_W-1:0] MEM_WB_WriteData,
  output logic [1:0]        ID_EX_WB,
  output logic [2:0]        ID_EX_M,
  output logic [3:0]        ID_EX_EX,
  output logic [DATA_W-1:0] ID_EX_NPC,
  output logic [DATA_W-1:0] ID_EX_RD1,
  output logic [DATA_W-1:0] ID_EX_RD2,
  output logic [DATA_W-1:0] ID_EX_SEXT,
  output logic [ADDR_W-1:0] ID_EX_RT,
  output logic [ADDR_W-1:0] ID_EX_RD
);

  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  ctrl_t             w_ctrl;

  instr_decode_stage_reg_file u_reg_file (
    .clk      (clk),
    .rst      (rst),
    .i_raddr1 (IF_ID_INSTR[25:21]),
    .i_raddr2 (IF_ID_INSTR[20:16]),
    .o_rdata1 (w_rd1),
    .o_rdata2 (w_rd2),
    .i_we     (MEM_WB_RegWrite),
    .i_waddr  (MEM_WB_WriteReg),
    .i_wdata  (MEM_WB_WriteData)
  );

  // A taken branch squashes only control; data fields are don't-care downstream
  always_comb begin
    w_ctrl = decode_ctrl(IF_ID_INSTR[31:26]);
    if (id_flush) w_ctrl = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ID_EX_WB   <= '0;
      ID_EX_M    <= '0;
      ID_EX_EX   <= '0;
      ID_EX_NPC  <= '0;
      ID_EX_RD1  <= '0;
      ID_EX_RD2  <= '0;
      ID_EX_SEXT <= '0;
      ID_EX_RT   <= '0;
      ID_EX_RD   <= '0;
    end else begin
      ID_EX_WB   <= w_ctrl.wb;
      ID_EX_M    <= w_ctrl.m;
      ID_EX_EX   <= w_ctrl.ex;
      ID_EX_NPC  <= IF_ID_NPC;
      ID_EX_RD1  <= w_rd1;
      ID_EX_RD2  <= w_rd2;
      ID_EX_SEXT <= {{16{IF_ID_INSTR[15]}}, IF_ID_INSTR[15:0]};
      ID_EX_RT   <= IF_ID_INSTR[20:16];
      ID_EX_RD   <= IF_ID_INSTR[15:11];
    end
  end

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb/tb_instr_decode_stage.sv - scoreboard bench for instr_decode_stage
module tb_instr_decode_stage;

  logic        clk;
  logic        rst;
  logic [31:0] IF_ID_INSTR;
  logic [31:0] IF_ID_NPC;
  logic        id_flush;
  logic        MEM_WB_RegWrite;
  logic [4:0]  MEM_WB_WriteReg;
  logic [31:0] MEM_WB_WriteData;
  logic [1:0]  ID_EX_WB;
  logic [2:0]  ID_EX_M;
  logic [3:0]  ID_EX_EX;
  logic [31:0] ID_EX_NPC;
  logic [31:0] ID_EX_RD1;
  logic [31:0] ID_EX_RD2;
  logic [31:0] ID_EX_SEXT;
  logic [4:0]  ID_EX_RT;
  logic [4:0]  ID_EX_RD;

  instr_decode_stage dut (
    .clk              (clk),
    .rst              (rst),
    .IF_ID_INSTR      (IF_ID_INSTR),
    .IF_ID_NPC        (IF_ID_NPC),
    .id_flush         (id_flush),
    .MEM_WB_RegWrite  (MEM_WB_RegWrite),
    .MEM_WB_WriteReg  (MEM_WB_WriteReg),
    .MEM_WB_WriteData (MEM_WB_WriteData),
    .ID_EX_WB         (ID_EX_WB),
    .ID_EX_M          (ID_EX_M),
    .ID_EX_EX         (ID_EX_EX),
    .ID_EX_NPC        (ID_EX_NPC),
    .ID_EX_RD1        (ID_EX_RD1),
    .ID_EX_RD2        (ID_EX_RD2),
    .ID_EX_SEXT       (ID_EX_SEXT),
    .ID_EX_RT         (ID_EX_RT),
    .ID_EX_RD         (ID_EX_RD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  ctrl;
    logic [31:0] npc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] sext;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_regs [32];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] ref_ctrl(input logic [5:0] op);
    case (op)
      6'h00:   return 9'b10_000_1100;
      6'h23:   return 9'b11_010_0001;
      6'h2B:   return 9'b00_001_0001;
      6'h04:   return 9'b00_100_0010;
      default: return 9'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'h0;
    if (we && wa == a) return wd;
    return m_regs[a];
  endfunction

  task automatic step(input logic r, input logic [31:0] instr, input logic [31:0] npc,
                      input logic fl, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input string tag);
    exp_t e;
    exp_t got;
    rst = r; IF_ID_INSTR = instr; IF_ID_NPC = npc; id_flush = fl;
    MEM_WB_RegWrite = we; MEM_WB_WriteReg = wa; MEM_WB_WriteData = wd;
    if (r) begin
      e = '{ctrl: 9'h0, npc: 32'h0, rd1: 32'h0, rd2: 32'h0, sext: 32'h0, rt: 5'h0, rd: 5'h0};
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    end else begin
      e.ctrl = fl ? 9'h0 : ref_ctrl(instr[31:26]);
      e.npc  = npc;
      e.rd1  = ref_read(instr[25:21], we, wa, wd);
      e.rd2  = ref_read(instr[20:16], we, wa, wd);
      e.sext = {{16{instr[15]}}, instr[15:0]};
      e.rt   = instr[20:16];
      e.rd   = instr[15:11];
      if (we && wa != 5'd0) m_regs[wa] = wd;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check({tag, ".ctrl"}, {23'h0, ID_EX_WB, ID_EX_M, ID_EX_EX}, {23'h0, got.ctrl});
    check({tag, ".npc"},  ID_EX_NPC,  got.npc);
    check({tag, ".rd1"},  ID_EX_RD1,  got.rd1);
    check({tag, ".rd2"},  ID_EX_RD2,  got.rd2);
    check({tag, ".sext"}, ID_EX_SEXT, got.sext);
    check({tag, ".rt"},   {27'h0, ID_EX_RT}, {27'h0, got.rt});
    check({tag, ".rd"},   {27'h0, ID_EX_RD}, {27'h0, got.rd});
  endtask

  initial begin
    logic [5:0]  ops [5];
    logic [31:0] ri;
    ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B; ops[3] = 6'h04; ops[4] = 6'h3F;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    rst = 1'b1; IF_ID_INSTR = '0; IF_ID_NPC = '0; id_flush = 1'b0;
    MEM_WB_RegWrite = 1'b0; MEM_WB_WriteReg = '0; MEM_WB_WriteData = '0;
    #1;

    step(1, 32'h0, 32'h0, 0, 0, 0, 0, "rst0");
    step(1, 32'h0, 32'h0, 0, 0, 0, 0, "rst1");
    for (int r = 0; r < 32; r += 2)
      step(0, {6'h3F, r[4:0], 5'(r + 1), 16'h0}, 32'h0, 0, 0, 0, 0, "rd_zero");

    step(0, 32'h0, 32'h0, 0, 1, 5'd1, 32'd5, "pre1");
    step(0, 32'h0, 32'h0, 0, 1, 5'd2, 32'd7, "pre2");
    step(0, 32'h00221820, 32'h4, 0, 0, 0, 0, "add");
    step(0, 32'h8C22FFFC, 32'h8, 0, 0, 0, 0, "lw");
    step(0, 32'hAC22_0010, 32'hC, 0, 0, 0, 0, "sw");
    step(0, 32'h8C22FFFC, 32'h10, 0, 1, 5'd1, 32'hDEADBEEF, "bypass");
    step(0, 32'h00010000, 32'h14, 0, 1, 5'd0, 32'h1234, "wr_r0");
    step(0, 32'h00010000, 32'h18, 0, 0, 0, 0, "rd_r0");
    step(0, 32'h00220000, 32'h1C, 0, 0, 5'd1, 32'h5555, "nobyp_we0");
    step(0, 32'hFC22_1234, 32'h20, 0, 0, 0, 0, "op3f");
    step(0, 32'h10220003, 32'h24, 1, 0, 0, 0, "beq_flush");
    step(0, 32'h10220003, 32'h28, 0, 0, 0, 0, "beq");
    step(0, 32'h8C22FFFC, 32'h2C, 0, 0, 0, 0, "lw2");
    step(1, 32'h8C22FFFC, 32'h30, 0, 1, 5'd3, 32'hAAAA, "rst_mid");
    step(0, 32'h00230000, 32'h34, 0, 0, 0, 0, "post_rst");

    for (int n = 0; n < 60; n++) begin
      ri = $urandom;
      ri[31:26] = ops[$urandom_range(0, 4)];
      step(0, ri, $urandom, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 7)), $urandom, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
